// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: one shared full-adder cell adds two WIDTH-bit operands LSB first.
// Optional macro SERIAL_ADD_SUB_EN adds a Sub input that turns the operation into A - B.
module serial_add_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             Sub,
`endif
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic             r_c;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;

   logic             w_accept;
   logic             w_last;
   logic             w_s;
   logic             w_c_nxt;
   logic [WIDTH:0]   w_cat;
   logic [WIDTH-1:0] w_res_nxt;
   logic [WIDTH-1:0] w_b_in;
   logic             w_c_init;

`ifdef SERIAL_ADD_SUB_EN
   // Two's-complement subtract: invert B and inject the +1 through the carry flop.
   assign w_b_in   = Sub ? ~B : B;
   assign w_c_init = Sub;
`else
   assign w_b_in   = B;
   assign w_c_init = 1'b0;
`endif

   assign w_s       = r_a[0] ^ r_b[0] ^ r_c;
   assign w_c_nxt   = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
   assign w_cat     = {w_s, r_res};
   assign w_res_nxt = w_cat[WIDTH:1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (r_cnt == LAST_BIT) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Result registers are written only on the last bit, so an aborted run never leaks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_c     <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
      end else if (w_accept) begin
         r_a   <= A;
         r_b   <= w_b_in;
         r_res <= '0;
         r_c   <= w_c_init;
         r_cnt <= '0;
      end else if (r_state == S_RUN) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_res <= w_res_nxt;
         r_c   <= w_c_nxt;
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_sum   <= w_res_nxt;
            r_carry <= w_c_nxt;
         end
      end
   end

   assign Sum   = r_sum;
   assign Carry = r_carry;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer (WIDTH=8); directed and random operations against an arithmetic model.
module tb_serial_add_sequencer;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         sub_i;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         busy;
   logic         done;
   logic [W-1:0] sum_o;
   logic         carry_o;

   int total = 0;
   int bad   = 0;

   serial_add_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
`ifdef SERIAL_ADD_SUB_EN
      .Sub   (sub_i),
`endif
      .A     (a_i),
      .B     (b_i),
      .busy  (busy),
      .done  (done),
      .Sum   (sum_o),
      .Carry (carry_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: result is plain integer arithmetic on the captured operands.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input bit inject, input string tag);
      logic [W-1:0] exp_sum;
      logic         exp_c;
      if (sub) begin
         exp_sum = W'(int'(a) - int'(b));
         exp_c   = (a >= b);
      end else begin
         exp_sum = W'(int'(a) + int'(b));
         exp_c   = ((int'(a) + int'(b)) > 255);
      end
      start = 1'b1; a_i = a; b_i = b; sub_i = sub;
      tick();
      start = 1'b0; a_i = W'($urandom); b_i = W'($urandom); sub_i = 1'($urandom);
      chk({tag, ".busy_t0"}, busy, 1);
      for (int k = 1; k <= W; k++) begin
         tick();
         if (inject && k == 3) begin
            start = 1'b1; a_i = 8'hFF; b_i = 8'hFF;
         end
         if (inject && k == 4) start = 1'b0;
         if (k < W) begin
            chk({tag, ".busy_run"}, busy, 1);
            chk({tag, ".nodone_run"}, done, 0);
         end else begin
            chk({tag, ".done"}, done, 1);
            chk({tag, ".busy_end"}, busy, 0);
            chk({tag, ".sum"}, sum_o, exp_sum);
            chk({tag, ".carry"}, carry_o, exp_c);
         end
      end
      tick();
      chk({tag, ".done_pulse"}, done, 0);
      chk({tag, ".sum_hold"}, sum_o, exp_sum);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] held;
      rst_n = 1'b0; start = 1'b0; sub_i = 1'b0; a_i = '0; b_i = '0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.sum", sum_o, 0);
      chk("rst.carry", carry_o, 0);

      run_op(8'h00, 8'h00, 1'b0, 1'b0, "zero");
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, "ovf");
      run_op(8'hA5, 8'h5A, 1'b0, 1'b0, "alt");
      for (int i = 0; i < 5; i++) tick();
      chk("hold.sum", sum_o, 8'hFF);
      chk("hold.carry", carry_o, 0);

      run_op(8'h12, 8'h34, 1'b0, 1'b1, "ign_start");

      // Abort an operation with reset in its 4th cycle.
      start = 1'b1; a_i = 8'h80; b_i = 8'h80;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) tick();
      rst_n = 1'b0;
      #1;
      chk("abort.busy", busy, 0);
      chk("abort.done", done, 0);
      chk("abort.sum", sum_o, 0);
      chk("abort.carry", carry_o, 0);
      tick();
      rst_n = 1'b1;
      held = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done) held = held + 1;
      end
      chk("abort.no_done", held, 0);
      run_op(8'h80, 8'h80, 1'b0, 1'b0, "after_abort");

      // Continuous start: one completion every W+2 cycles.
      start = 1'b1; a_i = 8'h01; b_i = 8'h01;
      for (int i = 1; i <= 30; i++) begin
         tick();
         chk("cont.done", done, ((i % (W + 2)) == (W + 1)) ? 1 : 0);
         if (done) chk("cont.sum", sum_o, 8'h02);
      end
      start = 1'b0;
      for (int i = 0; i < W + 2; i++) tick();
      chk("cont.idle", busy, 0);

`ifdef SERIAL_ADD_SUB_EN
      run_op(8'h05, 8'h07, 1'b1, 1'b0, "sub_neg");
      run_op(8'h07, 8'h05, 1'b1, 1'b0, "sub_pos");
`endif

      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
         run_op(ra, rb, 1'($urandom), 1'b0, "rand");
`else
         run_op(ra, rb, 1'b0, 1'b0, "rand");
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
